bus_timer: RTL and testbench

//  Memory-mapped timer that acts as a responder on the word-addressed memory bus driven by mem_ctrl.
//  The bus signals are addr, as_, rw, wr_data and rd_data. The timer sits beside memory on that bus.
//  It decodes a 4-word register window, counts clock cycles, flags expiry and raises a level interrupt.

---
 rtl/bus_timer_pkg.sv | 28 ++
 rtl/bus_timer_core.sv | 63 ++++++
 rtl/bus_timer.sv | 108 ++++++++++
 tb/tb_bus_timer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped bus timer: bus encodings, register
// offsets inside the 4-word window, and field bit positions.
package bus_timer_pkg;

  localparam int WORD_ADDR_W    = 30;  // word address bus width
  localparam int DATA_WIDTH_GPR = 32;  // general register / bus data width

  // Bus direction encoding used by mem_ctrl
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Register offsets (addr[1:0])
  typedef enum logic [1:0] {
    TIMER_REG_CTRL   = 2'd0,
    TIMER_REG_STATUS = 2'd1,
    TIMER_REG_LIMIT  = 2'd2,
    TIMER_REG_COUNT  = 2'd3
  } timer_reg_e;

  // CTRL field positions
  localparam int TIMER_CTRL_EN  = 0;
  localparam int TIMER_CTRL_PER = 1;
  localparam int TIMER_CTRL_IE  = 2;

  // STATUS field positions
  localparam int TIMER_STATUS_EXP = 0;

endpackage

// File: rtl/bus_timer_core.sv
// Counting engine: owns COUNT and the sticky EXP flag, and tells the register
// block when a one-shot expiry must clear EN. Bus writes arrive as override
// strobes so that write-versus-count collisions are resolved in one place.
module bus_timer_core
  import bus_timer_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH_GPR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,           // CTRL.EN as currently registered
  input  logic              per,          // CTRL.PER
  input  logic [DATA_W-1:0] limit,        // LIMIT as currently registered
  input  logic              count_wr,     // bus write to COUNT this cycle
  input  logic [DATA_W-1:0] count_wdata,
  input  logic              status_w1c,   // bus write of 1 to STATUS.EXP
  output logic [DATA_W-1:0] count_q,
  output logic              exp_q,
  output logic              en_clear      // one-shot expiry: drop EN
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] count_d;
  logic              exp_d;

  // Next COUNT / EXP: a COUNT write suppresses both increment and match,
  // and an expiry in the same cycle as a W1C keeps EXP set.
  always_comb begin
    count_d  = count_q;
    exp_d    = exp_q;
    en_clear = 1'b0;
    if (status_w1c) begin
      exp_d = 1'b0;
    end
    if (count_wr) begin
      count_d = count_wdata;
    end else if (en) begin
      if (count_q != limit) begin
        count_d = count_q + ONE;
      end else begin
        exp_d = 1'b1;
        if (per) begin
          count_d = '0;
        end else begin
          en_clear = 1'b1;
        end
      end
    end
  end

  // COUNT / EXP state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer responder: decodes a 4-word window on the word-addressed
// bus, holds CTRL and LIMIT, drives a zero-latency read mux and a level irq.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [WORD_ADDR_W-1:0] BASE_ADDR = 30'h0000_1000,
  parameter int                     DATA_W    = DATA_WIDTH_GPR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   cs,
  output logic                   irq
);

  timer_reg_e        reg_idx;
  logic              wr_en;
  logic              rd_en;

  logic              en_q, en_d;
  logic              per_q, per_d;
  logic              ie_q, ie_d;
  logic [DATA_W-1:0] limit_q, limit_d;

  logic [DATA_W-1:0] count_val;
  logic              exp_val;
  logic              en_clear;

  // Window decode: upper address bits select the block, low two pick the register
  assign cs      = !as_ && (addr[WORD_ADDR_W-1:2] == BASE_ADDR[WORD_ADDR_W-1:2]);
  assign reg_idx = timer_reg_e'(addr[1:0]);
  assign wr_en   = cs && (rw == WRITE);
  assign rd_en   = cs && (rw == READ);
  assign irq     = exp_val & ie_q;

  bus_timer_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .en          (en_q),
    .per         (per_q),
    .limit       (limit_q),
    .count_wr    (wr_en && (reg_idx == TIMER_REG_COUNT)),
    .count_wdata (wr_data),
    .status_w1c  (wr_en && (reg_idx == TIMER_REG_STATUS) && wr_data[TIMER_STATUS_EXP]),
    .count_q     (count_val),
    .exp_q       (exp_val),
    .en_clear    (en_clear)
  );

  // Next CTRL / LIMIT: a CTRL write overrides the one-shot EN auto-clear
  always_comb begin
    en_d    = en_q;
    per_d   = per_q;
    ie_d    = ie_q;
    limit_d = limit_q;
    if (en_clear) begin
      en_d = 1'b0;
    end
    if (wr_en && (reg_idx == TIMER_REG_CTRL)) begin
      en_d  = wr_data[TIMER_CTRL_EN];
      per_d = wr_data[TIMER_CTRL_PER];
      ie_d  = wr_data[TIMER_CTRL_IE];
    end
    if (wr_en && (reg_idx == TIMER_REG_LIMIT)) begin
      limit_d = wr_data;
    end
  end

  // CTRL / LIMIT registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      ie_q    <= 1'b0;
      limit_q <= '0;
    end else begin
      en_q    <= en_d;
      per_q   <= per_d;
      ie_q    <= ie_d;
      limit_q <= limit_d;
    end
  end

  // Zero-latency read mux; drives 0 unless this block is read
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (reg_idx)
        TIMER_REG_CTRL: begin
          rd_data[TIMER_CTRL_EN]  = en_q;
          rd_data[TIMER_CTRL_PER] = per_q;
          rd_data[TIMER_CTRL_IE]  = ie_q;
        end
        TIMER_REG_STATUS: rd_data[TIMER_STATUS_EXP] = exp_val;
        TIMER_REG_LIMIT:  rd_data = limit_q;
        TIMER_REG_COUNT:  rd_data = count_val;
        default:          rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: vector table, directed corner sequences
// and a randomized run, all compared against a behavioural register model.
module tb_bus_timer;

  localparam logic [29:0] BASE = 30'h0000_1000;
  localparam logic [29:0] ALT  = 30'h0000_1004;  // next window, must not decode
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  localparam int CTRL = 0, STATUS = 1, LIMIT = 2, COUNT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] addr = '0;
  logic        as_ = 1'b1;
  logic        rw = RD;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        cs;
  logic        irq;

  bus_timer #(.BASE_ADDR(BASE), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .as_(as_), .rw(rw),
    .wr_data(wr_data), .rd_data(rd_data), .cs(cs), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural register model
  logic        m_en, m_per, m_ie, m_exp;
  logic [31:0] m_limit, m_count;

  // Values observed in the most recent cycle
  logic [31:0] last_rd;
  logic        last_cs, last_irq;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, expv);
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] idx);
    case (idx)
      2'd0:    return {29'd0, m_ie, m_per, m_en};
      2'd1:    return {31'd0, m_exp};
      2'd2:    return m_limit;
      default: return m_count;
    endcase
  endfunction

  function automatic logic model_sel(input logic as_n, input logic [29:0] a);
    return !as_n && (a[29:2] == BASE[29:2]);
  endfunction

  // Apply one clock worth of the timer rules to the model
  task automatic model_step(input logic as_n, input logic [29:0] a, input logic rw_i,
                            input logic [31:0] wd, input logic rst_i);
    logic        wr, expire;
    logic [1:0]  idx;
    logic        n_en, n_per, n_ie, n_exp;
    logic [31:0] n_limit, n_count;
    if (rst_i) begin
      m_en = 0; m_per = 0; m_ie = 0; m_exp = 0; m_limit = 0; m_count = 0;
      return;
    end
    wr  = model_sel(as_n, a) && (rw_i == WR);
    idx = a[1:0];
    n_en = m_en; n_per = m_per; n_ie = m_ie; n_exp = m_exp;
    n_limit = m_limit; n_count = m_count;
    expire = 1'b0;
    if (m_en && !(wr && idx == 2'd3)) begin
      if (m_count == m_limit) begin
        expire = 1'b1;
        if (m_per) n_count = 0;
        else n_en = 1'b0;
      end else begin
        n_count = m_count + 1;
      end
    end
    if (expire) n_exp = 1'b1;
    if (wr) begin
      case (idx)
        2'd0: {n_ie, n_per, n_en} = wd[2:0];
        2'd1: if (wd[0] && !expire) n_exp = 1'b0;
        2'd2: n_limit = wd;
        default: n_count = wd;
      endcase
    end
    m_en = n_en; m_per = n_per; m_ie = n_ie; m_exp = n_exp;
    m_limit = n_limit; m_count = n_count;
  endtask

  // One bus cycle: drive, sample at negedge against the model, clock, update model
  task automatic cycle(input logic as_n, input logic [29:0] a, input logic rw_i,
                       input logic [31:0] wd, input logic rst_i);
    logic        e_sel;
    logic [31:0] e_rd;
    rst = rst_i; as_ = as_n; addr = a; rw = rw_i; wr_data = wd;
    @(negedge clk);
    last_rd = rd_data; last_cs = cs; last_irq = irq;
    if (!rst_i) begin
      e_sel = model_sel(as_n, a);
      e_rd  = (e_sel && rw_i == RD) ? model_reg(a[1:0]) : 32'd0;
      chk("model_cs", {31'd0, cs}, {31'd0, e_sel});
      chk("model_rd_data", rd_data, e_rd);
      chk("model_irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
    end
    @(posedge clk);
    model_step(as_n, a, rw_i, wd, rst_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, '0, RD, '0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b1, '0, RD, '0, 1'b0);
  endtask

  task automatic bus_wr(input int idx, input logic [31:0] d);
    cycle(1'b0, BASE + 30'(idx), WR, d, 1'b0);
  endtask

  task automatic rd_expect(input string name, input int idx, input logic [31:0] v);
    cycle(1'b0, BASE + 30'(idx), RD, '0, 1'b0);
    chk(name, last_rd, v);
  endtask

  typedef struct {
    logic        as_n;
    logic [29:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_cs;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Decode / back-to-back table, applied right after a reset
    vecs[0] = '{1'b0, BASE + 30'd2, WR, 32'h0123_4567, 32'h0,          1'b1};
    vecs[1] = '{1'b0, BASE + 30'd2, RD, 32'h0,          32'h0123_4567, 1'b1};
    vecs[2] = '{1'b1, BASE + 30'd2, RD, 32'h0,          32'h0,          1'b0};
    vecs[3] = '{1'b0, ALT  + 30'd2, WR, 32'h0000_dead, 32'h0,          1'b0};
    vecs[4] = '{1'b0, BASE + 30'd2, RD, 32'h0,          32'h0123_4567, 1'b1};
    vecs[5] = '{1'b1, BASE + 30'd2, WR, 32'h0000_ffff, 32'h0,          1'b0};
    vecs[6] = '{1'b0, BASE + 30'd2, RD, 32'h0,          32'h0123_4567, 1'b1};
    vecs[7] = '{1'b0, ALT  + 30'd2, RD, 32'h0,          32'h0,          1'b0};
    vecs[8] = '{1'b0, BASE + 30'd0, RD, 32'h0,          32'h0,          1'b1};
    vecs[9] = '{1'b0, BASE + 30'd3, RD, 32'h0,          32'h0,          1'b1};

    // Reset: every register 0, irq 0, cs 0 when idle
    do_reset(2);
    idle();
    chk("reset_cs_idle", {31'd0, last_cs}, 32'd0);
    chk("reset_rd_idle", last_rd, 32'd0);
    rd_expect("reset_ctrl", CTRL, 32'd0);
    rd_expect("reset_status", STATUS, 32'd0);
    rd_expect("reset_limit", LIMIT, 32'd0);
    rd_expect("reset_count", COUNT, 32'd0);
    chk("reset_irq", {31'd0, last_irq}, 32'd0);

    // One-shot: COUNT reaches 5 after 5 edges, match registers on the 6th
    do_reset(1);
    bus_wr(LIMIT, 32'd5);
    bus_wr(CTRL, 32'h5);
    for (int j = 1; j <= 6; j++) begin
      rd_expect($sformatf("oneshot_status_c%0d", j), STATUS, 32'd0);
      chk($sformatf("oneshot_irq_c%0d", j), {31'd0, last_irq}, 32'd0);
    end
    rd_expect("oneshot_status_set", STATUS, 32'd1);
    chk("oneshot_irq_set", {31'd0, last_irq}, 32'd1);
    rd_expect("oneshot_count", COUNT, 32'd5);
    rd_expect("oneshot_ctrl", CTRL, 32'h4);

    // Periodic LIMIT=3: 0,1,2,3,0,... then W1C and collision cases
    do_reset(1);
    bus_wr(LIMIT, 32'd3);
    bus_wr(CTRL, 32'h3);
    for (int j = 1; j <= 8; j++)
      rd_expect($sformatf("periodic_count_c%0d", j), COUNT, 32'((j - 1) % 4));
    bus_wr(STATUS, 32'd1);                  // COUNT=0: plain clear
    rd_expect("periodic_w1c", STATUS, 32'd0);
    idle();                                 // COUNT=2
    bus_wr(STATUS, 32'd1);                  // COUNT=3: expiry wins
    rd_expect("collide_w1c_vs_set", STATUS, 32'd1);
    bus_wr(STATUS, 32'd1);                  // COUNT=1: clear
    idle();                                 // COUNT=2
    bus_wr(COUNT, 32'd100);                 // COUNT=3: write wins, no match
    rd_expect("collide_count_wr", COUNT, 32'd100);
    rd_expect("collide_count_exp", STATUS, 32'd0);

    // LIMIT=0 periodic: EXP set every cycle, so W1C never sticks
    do_reset(1);
    bus_wr(CTRL, 32'h3);
    idle();
    bus_wr(STATUS, 32'd1);
    rd_expect("limit0_status", STATUS, 32'd1);

    // Decode and back-to-back table
    do_reset(1);
    foreach (vecs[i]) begin
      cycle(vecs[i].as_n, vecs[i].addr, vecs[i].rw, vecs[i].wdata, 1'b0);
      chk($sformatf("vec%0d_rd", i), last_rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_cs", i), {31'd0, last_cs}, {31'd0, vecs[i].exp_cs});
    end

    // Mid-run reset clears state and discards a concurrent write
    bus_wr(CTRL, 32'h7);
    idle();
    cycle(1'b0, BASE + 30'd2, WR, 32'h0000_0abc, 1'b1);
    rst = 1'b0;
    rd_expect("midrst_limit", LIMIT, 32'd0);
    rd_expect("midrst_ctrl", CTRL, 32'd0);
    rd_expect("midrst_count", COUNT, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic        r_as, r_rw, r_rst;
      logic [31:0] r_a32, r_wd;
      logic [29:0] r_addr;
      int          r_sel;
      r_as  = ($urandom % 8) == 0;
      r_rw  = $urandom_range(0, 1) == 1;
      r_rst = ($urandom % 100) == 0;
      r_sel = $urandom % 10;
      r_a32 = $urandom;
      if (r_sel < 8)       r_addr = BASE + 30'($urandom % 4);
      else if (r_sel == 8) r_addr = ALT + 30'($urandom % 4);
      else                 r_addr = r_a32[29:0];
      r_wd = (($urandom % 8) == 0) ? 32'($urandom) : 32'($urandom % 12);
      cycle(r_as, r_addr, r_rw, r_wd, r_rst);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
